btb_predictor: RTL

BTB_PREDICTOR -- requirements
Module: btb_predictor

---
 rtl/bpu_pkg.sv | 24 ++
 rtl/plru_tree.sv | 48 ++++
 rtl/btb_predictor.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bpu_pkg.sv
// Shared types and constants for the branch prediction unit.
package bpu_pkg;

  localparam int BR_WD = 33;

  localparam logic [1:0] CNT_SNT   = 2'b00;
  localparam logic [1:0] CNT_WNT   = 2'b01;
  localparam logic [1:0] CNT_WT    = 2'b10;
  localparam logic [1:0] CNT_ST    = 2'b11;
  localparam logic [1:0] CNT_ALLOC = 2'b10;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Binary-tree pseudo-LRU state: one bit per internal node, heap ordered (root = 1).
// A set bit steers the victim search to the right child; a touch points every node on its path away.
module plru_tree
  import bpu_pkg::*;
#(
  parameter int ENTRIES = 16,
  localparam int IW = clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          touch_valid,
  input  logic [IW-1:0] touch_index,
  output logic [IW-1:0] victim
);

  logic [ENTRIES-1:1] plru_reg;
  logic [ENTRIES-1:1] plru_next;
  logic [IW:0]        leaf;

  assign leaf = {1'b1, touch_index};

  generate
    for (genvar gi = 1; gi < ENTRIES; gi++) begin : g_node
      localparam int LVL = clog2(gi + 1) - 1;
      logic on_path;
      assign on_path = touch_valid && ((leaf >> (IW - LVL)) == (IW + 1)'(gi));
      assign plru_next[gi] = on_path ? ~touch_index[IW-1-LVL] : plru_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      plru_reg <= '0;
    end else begin
      plru_reg <= plru_next;
    end
  end

  always_comb begin
    logic [IW:0] node;
    node = (IW + 1)'(1);
    for (int l = 0; l < IW; l++) begin
      node = {node[IW-1:0], plru_reg[node[IW-1:0]]};
    end
    victim = node[IW-1:0];
  end

endmodule

// File: rtl/btb_predictor.sv
// Fully associative branch target buffer with PLRU replacement and a DELAY-deep prediction pipeline.
// Define BTB_COUNTER_EN for 2-bit saturating counters; otherwise any hit predicts taken.
module btb_predictor
  import bpu_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int DELAY   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      lookup_pc0,
  input  logic [31:0]      lookup_pc1,
  input  logic             upd_valid,
  input  logic             upd_taken,
  input  logic [31:0]      upd_pc,
  input  logic [31:0]      upd_target,
  output logic [BR_WD-1:0] bp_bus,
  output logic [BR_WD-1:0] bp_id_bus,
  output logic             slot_invalid
);

  localparam int IW = clog2(ENTRIES);

  logic [ENTRIES-1:0] valid_reg;
  logic [31:0]        tag_reg    [ENTRIES];
  logic [31:0]        target_reg [ENTRIES];
`ifdef BTB_COUNTER_EN
  logic [1:0]         cnt_reg    [ENTRIES];
`endif

  logic [ENTRIES-1:0] hit_vec, slot0_vec, upd_vec;
  logic [IW-1:0]      sel_idx, slot0_idx, upd_idx, free_idx, alloc_idx, victim;
  logic               any_hit, slot0_hit, upd_hit, has_free;
  logic               pred_taken, slot0_taken, alloc;
  br_t                pred_br;

  br_t                stage_reg [DELAY:1];
  logic [DELAY:1]     slot_reg;

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cmp
      assign hit_vec[gi]   = valid_reg[gi] && (tag_reg[gi] == lookup_pc0 || tag_reg[gi] == lookup_pc1);
      assign slot0_vec[gi] = valid_reg[gi] && (tag_reg[gi] == lookup_pc0);
      assign upd_vec[gi]   = valid_reg[gi] && (tag_reg[gi] == upd_pc);
    end
  endgenerate

  // Descending scans so the lowest index wins every priority choice.
  always_comb begin
    sel_idx   = '0;
    any_hit   = 1'b0;
    slot0_idx = '0;
    slot0_hit = 1'b0;
    upd_idx   = '0;
    upd_hit   = 1'b0;
    free_idx  = '0;
    has_free  = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        sel_idx = IW'(i);
        any_hit = 1'b1;
      end
      if (slot0_vec[i]) begin
        slot0_idx = IW'(i);
        slot0_hit = 1'b1;
      end
      if (upd_vec[i]) begin
        upd_idx = IW'(i);
        upd_hit = 1'b1;
      end
      if (!valid_reg[i]) begin
        free_idx = IW'(i);
        has_free = 1'b1;
      end
    end
  end

`ifdef BTB_COUNTER_EN
  assign pred_taken  = any_hit && cnt_reg[sel_idx][1];
  assign slot0_taken = slot0_hit && cnt_reg[slot0_idx][1];
`else
  assign pred_taken  = any_hit;
  assign slot0_taken = slot0_hit;
`endif

  assign pred_br.taken  = pred_taken;
  assign pred_br.target = pred_taken ? target_reg[sel_idx] : 32'h0;

  assign alloc     = upd_valid && upd_taken && !upd_hit;
  assign alloc_idx = has_free ? free_idx : victim;

  plru_tree #(
    .ENTRIES(ENTRIES)
  ) u_plru (
    .clk        (clk),
    .rst        (rst),
    .touch_valid(alloc || any_hit),
    .touch_index(alloc ? alloc_idx : sel_idx),
    .victim     (victim)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
    end else if (alloc) begin
      valid_reg[alloc_idx] <= 1'b1;
`ifndef BTB_COUNTER_EN
    end else if (upd_valid && upd_hit && !upd_taken) begin
      valid_reg[upd_idx] <= 1'b0;
`endif
    end
  end

  // Payload carries no reset; valid_reg gates its use.
  always_ff @(posedge clk) begin
    if (!rst && upd_valid) begin
      if (upd_hit && upd_taken) begin
        target_reg[upd_idx] <= upd_target;
`ifdef BTB_COUNTER_EN
        cnt_reg[upd_idx] <= (cnt_reg[upd_idx] == CNT_ST) ? CNT_ST : cnt_reg[upd_idx] + 2'd1;
`endif
      end else if (upd_hit) begin
`ifdef BTB_COUNTER_EN
        cnt_reg[upd_idx] <= (cnt_reg[upd_idx] == CNT_SNT) ? CNT_SNT : cnt_reg[upd_idx] - 2'd1;
`endif
      end else if (upd_taken) begin
        tag_reg[alloc_idx]    <= upd_pc;
        target_reg[alloc_idx] <= upd_target;
`ifdef BTB_COUNTER_EN
        cnt_reg[alloc_idx]    <= CNT_ALLOC;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int k = 1; k <= DELAY; k++) begin
        stage_reg[k] <= '0;
      end
      slot_reg <= '0;
    end else if (!stall) begin
      stage_reg[1] <= pred_br;
      slot_reg[1]  <= slot0_taken;
      for (int k = DELAY; k >= 2; k--) begin
        stage_reg[k] <= stage_reg[k-1];
        slot_reg[k]  <= slot_reg[k-1];
      end
    end
  end

  assign bp_bus       = stage_reg[1];
  assign bp_id_bus    = stage_reg[DELAY];
  assign slot_invalid = slot_reg[DELAY];

endmodule
